// File: rtl/alu_issue_ctrl.sv
// Issue/writeback control stage wrapped around the external 16-bit flag-producing ALU.
// Owns an 8-entry register file, sequences IDLE -> EXEC -> WB, and maintains the architectural flags.
module alu_issue_ctrl #(
    parameter int NREG = 8,
    parameter int DW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [11:0]   instr,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [2:0]    ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_sign,
    input  logic          alu_zero,
    input  logic          alu_parity,
    input  logic          alu_ovf,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          flag_s,
    output logic          flag_z,
    output logic          flag_p,
    output logic          flag_v,
    output logic          ovf_sticky,
    input  logic          clr_sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t        state;
    logic          rdy;
    logic [2:0]    rd_q;
    logic [DW-1:0] rf [NREG];

    logic [2:0] i_op, i_rd, i_rs1, i_rs2;
    assign i_op  = instr[11:9];
    assign i_rd  = instr[8:6];
    assign i_rs1 = instr[5:3];
    assign i_rs2 = instr[2:0];

    assign instr_ready = rdy;
    assign ld_ready    = rdy;

    // Operands are latched at the accept edge; a load landing on that same edge is forwarded so
    // the accepted instruction sees the freshly loaded value. The ALU result is captured at the
    // end of EXEC straight into result/flags/rf, which are what the WB cycle presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rdy    <= 1'b0;
            rd_q   <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            done   <= 1'b0;
            result <= '0;
            flag_s <= 1'b0;
            flag_z <= 1'b0;
            flag_p <= 1'b0;
            flag_v <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rdy) begin
                        if (ld_valid) begin
                            rf[ld_addr] <= ld_data;
                        end
                        if (instr_valid) begin
                            alu_a  <= (ld_valid && ld_addr == i_rs1) ? ld_data : rf[i_rs1];
                            alu_b  <= (ld_valid && ld_addr == i_rs2) ? ld_data : rf[i_rs2];
                            alu_op <= i_op;
                            rd_q   <= i_rd;
                            rdy    <= 1'b0;
                            state  <= EXEC;
                        end
                    end else begin
                        rdy <= 1'b1;
                    end
                end
                EXEC: begin
                    // Sign is meaningless for logic/shift ops; overflow only exists for ADD.
                    rf[rd_q] <= alu_out;
                    result   <= alu_out;
                    flag_z   <= alu_zero;
                    flag_p   <= alu_parity;
                    flag_s   <= (alu_op[2:1] == 2'b00) ? alu_sign : 1'b0;
                    flag_v   <= (alu_op == 3'b000) ? alu_ovf : 1'b0;
                    done     <= 1'b1;
                    state    <= WB;
                end
                WB: begin
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    rdy   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky set is taken on the edge closing WB so that a clear in that same cycle loses.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (state == WB && flag_v) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed scenarios plus randomized traffic against
// a behavioural register-file/flag model; a negedge monitor pops expectations on every done.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, instr_ready;
    logic [11:0] instr;
    logic        ld_valid, ld_ready;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_out;
    logic        alu_sign, alu_zero, alu_parity, alu_ovf;
    logic        done;
    logic [15:0] result;
    logic        flag_s, flag_z, flag_p, flag_v, ovf_sticky, clr_sticky;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] res;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic        s, z, p, v;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] mrf[8];
    logic        msticky;
    logic        junk_s = 1'b0, junk_v = 1'b0, force_junk = 1'b0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .alu_sign(alu_sign), .alu_zero(alu_zero), .alu_parity(alu_parity), .alu_ovf(alu_ovf),
        .done(done), .result(result),
        .flag_s(flag_s), .flag_z(flag_z), .flag_p(flag_p), .flag_v(flag_v),
        .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
    );

    function automatic logic [15:0] aluFunc(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    // ALU stand-in; undefined flags are driven with noise so the stage must mask them.
    always @(posedge clk) begin
        junk_s <= force_junk ? 1'b1 : 1'($urandom_range(0, 1));
        junk_v <= force_junk ? 1'b1 : 1'($urandom_range(0, 1));
    end

    always_comb begin
        alu_out    = aluFunc(alu_op, alu_a, alu_b);
        alu_zero   = (alu_out == 16'h0000);
        alu_parity = ~^alu_out;
        alu_sign   = (alu_op[2:1] == 2'b00) ? alu_out[15] : junk_s;
        alu_ovf    = (alu_op == 3'd0) ? ((alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15])) : junk_v;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_done", done, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("result", result, e.res);
                checkOutput("flag_s", flag_s, e.s);
                checkOutput("flag_z", flag_z, e.z);
                checkOutput("flag_p", flag_p, e.p);
                checkOutput("flag_v", flag_v, e.v);
                checkOutput("alu_a", alu_a, e.a);
                checkOutput("alu_b", alu_b, e.b);
                checkOutput("alu_op", alu_op, e.op);
            end
        end
    end

    task automatic waitReady();
        int guard = 0;
        while (instr_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (instr_ready !== 1'b1) checkOutput("ready_timeout", instr_ready, 1);
    endtask

    task automatic doLoad(input logic [2:0] addr, input logic [15:0] data);
        waitReady();
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        @(posedge clk); #1;
        ld_valid  = 1'b0;
        mrf[addr] = data;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                 input logic [2:0] rs2, input logic ld, input logic [2:0] la,
                                 input logic [15:0] ldd, input logic clr_wb);
        exp_t e;
        int   sum;
        waitReady();
        instr       = {op, rd, rs1, rs2};
        instr_valid = 1'b1;
        ld_valid    = ld;
        ld_addr     = la;
        ld_data     = ldd;
        @(posedge clk); #1;
        if (ld) mrf[la] = ldd;
        e.a   = mrf[rs1];
        e.b   = mrf[rs2];
        e.op  = op;
        e.res = aluFunc(op, e.a, e.b);
        e.z   = (e.res == 16'h0000);
        e.p   = ($countones(e.res) % 2) == 0;
        e.s   = (op <= 3'd1) ? e.res[15] : 1'b0;
        sum   = int'($signed(e.a)) + int'($signed(e.b));
        e.v   = (op == 3'd0) && (sum > 32767 || sum < -32768);
        mrf[rd] = e.res;
        sbq.push_back(e);
        instr       = 12'($urandom);
        ld_valid    = 1'b1;
        ld_addr     = 3'($urandom);
        ld_data     = 16'($urandom);
        @(negedge clk);
        checkOutput("exec_instr_ready", instr_ready, 0);
        checkOutput("exec_ld_ready", ld_ready, 0);
        checkOutput("exec_done", done, 0);
        @(posedge clk); #1;
        clr_sticky = clr_wb;
        @(negedge clk);
        checkOutput("wb_instr_ready", instr_ready, 0);
        checkOutput("wb_done", done, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        ld_valid    = 1'b0;
        clr_sticky  = 1'b0;
        if (e.v) msticky = 1'b1;
        else if (clr_wb) msticky = 1'b0;
        @(negedge clk);
        checkOutput("idle_instr_ready", instr_ready, 1);
        checkOutput("ovf_sticky", ovf_sticky, msticky);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; ld_valid = 1'b0; ld_addr = '0;
        ld_data = '0; clr_sticky = 1'b0; msticky = 1'b0;
        for (int i = 0; i < 8; i++) mrf[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_instr_ready", instr_ready, 0);
        checkOutput("rst_ld_ready", ld_ready, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_flags", {flag_s, flag_z, flag_p, flag_v, ovf_sticky}, 0);
        checkOutput("rst_alu", {alu_a, alu_b, 13'(alu_op)}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("post_rst_ready", instr_ready, 1);

        $display("[TB] overflowing ADD");
        doLoad(3'd1, 16'h7FFF);
        doLoad(3'd2, 16'h0001);
        applyStimulus(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0);
        checkOutput("t1_result", result, 16'h8000);
        checkOutput("t1_flags_szpv", {flag_s, flag_z, flag_p, flag_v}, 4'b1001);
        checkOutput("t1_sticky", ovf_sticky, 1);

        $display("[TB] SUB to zero");
        doLoad(3'd4, 16'h0005);
        doLoad(3'd5, 16'h0005);
        applyStimulus(3'd1, 3'd6, 3'd4, 3'd5, 1'b0, 3'd0, 16'h0, 1'b0);
        checkOutput("t2_result", result, 16'h0000);
        checkOutput("t2_flags_szpv", {flag_s, flag_z, flag_p, flag_v}, 4'b0110);
        checkOutput("t2_sticky", ovf_sticky, 1);

        $display("[TB] XOR with noisy sign/ovf");
        force_junk = 1'b1;
        doLoad(3'd1, 16'h00FF);
        doLoad(3'd2, 16'h0F0F);
        applyStimulus(3'd4, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0);
        force_junk = 1'b0;
        checkOutput("t3_result", result, 16'h0FF0);
        checkOutput("t3_flags_szpv", {flag_s, flag_z, flag_p, flag_v}, 4'b0010);

        $display("[TB] clear versus set in WB");
        doLoad(3'd1, 16'h7FFF);
        doLoad(3'd2, 16'h0001);
        applyStimulus(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0, 1'b1);
        checkOutput("t4_set_wins", ovf_sticky, 1);
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        msticky    = 1'b0;
        @(negedge clk);
        checkOutput("t4_cleared", ovf_sticky, 0);

        $display("[TB] aliasing");
        doLoad(3'd1, 16'h0003);
        applyStimulus(3'd0, 3'd1, 3'd1, 3'd1, 1'b0, 3'd0, 16'h0, 1'b0);
        checkOutput("t5_result", result, 16'h0006);
        applyStimulus(3'd3, 3'd7, 3'd1, 3'd1, 1'b1, 3'd0, 16'h0000, 1'b0);
        checkOutput("t5_r1_readback", result, 16'h0006);

        $display("[TB] reset during EXEC");
        doLoad(3'd1, 16'h1234);
        waitReady();
        instr = {3'd0, 3'd2, 3'd1, 3'd1};
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) mrf[i] = '0;
        msticky = 1'b0;
        @(negedge clk);
        checkOutput("t6_done", done, 0);
        checkOutput("t6_ready_in_rst", instr_ready, 0);
        checkOutput("t6_result", result, 0);
        checkOutput("t6_flags", {flag_s, flag_z, flag_p, flag_v, ovf_sticky}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t6_ready_after", instr_ready, 1);
        checkOutput("t6_done_after", done, 0);
        applyStimulus(3'd3, 3'd3, 3'd2, 3'd1, 1'b0, 3'd0, 16'h0, 1'b0);
        checkOutput("t6_r2_zero", result, 16'h0000);

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            int unsigned kind = $urandom_range(0, 3);
            logic [2:0] rs1 = 3'($urandom);
            if (kind == 0) begin
                doLoad(3'($urandom), 16'($urandom));
            end else begin
                applyStimulus(3'($urandom), 3'($urandom), rs1, 3'($urandom),
                              1'($urandom_range(0, 1)),
                              (kind == 1) ? rs1 : 3'($urandom),
                              16'($urandom), ($urandom_range(0, 3) == 0));
            end
        end

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Upstream control stage for the 16-bit flag-producing ALU. It holds an 8 x 16-bit register file and accepts 3-operand instructions over a valid/ready handshake. It drives the ALU's A, B and Op inputs, captures the combinational result and flags, then writes the result back to the register file and updates an architectural flag register. A side load port initialises registers.

Parameters:
NREG, 8, number of registers (index width = 3; fixed at 8 for this revision)
DW, 16, data width; must match the ALU width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  stage can accept an instruction
instr  input  12  {op[11:9], rd[8:6], rs1[5:3], rs2[2:0]}
ld_valid  input  1  register load request
ld_ready  output  1  load accepted this cycle
ld_addr  input  3  load target register
ld_data  input  16  load value
alu_a  output  16  ALU operand A = rf[rs1]
alu_b  output  16  ALU operand B = rf[rs2]
alu_op  output  3  ALU opcode
alu_out  input  16  ALU result
alu_sign, alu_zero, alu_parity, alu_ovf  input  1 each  ALU flags
done  output  1  one-cycle pulse: writeback occurred
result  output  16  value written back; held until next writeback
flag_s, flag_z, flag_p, flag_v  output  1 each  architectural flags
ovf_sticky  output  1  sticky overflow
clr_sticky  input  1  clears ovf_sticky

Behaviour:
- Reset: state=IDLE, all rf entries=0, instr_ready=0 in the reset cycle, ld_ready=0, alu_a/alu_b/alu_op=0, done=0, result=0, all flags=0, ovf_sticky=0.
- FSM IDLE -> EXEC -> WB -> IDLE. No other states.
- IDLE: instr_ready=1 and ld_ready=1. If instr_valid=1, latch instr and go to EXEC.
  - If ld_valid=1 in the same cycle, the load also completes: rf[ld_addr]=ld_data at that edge.
  - EXEC reads rf registered after this edge, so the new load value is visible to the accepted instruction.
- EXEC: alu_a=rf[rs1], alu_b=rf[rs2], alu_op=op, all driven from registered state. At the end of EXEC, capture alu_out and the four flags into internal regs, then go to WB.
- WB, flags:
  - rf[rd]=captured result; result updated; done=1 for exactly this cycle.
  - flag_z and flag_p take the captured values.
  - flag_s takes captured alu_sign only if op[2:1]==2'b00; otherwise it is forced to 0. The ALU sign is undefined for non-arithmetic ops and must never be sampled.
  - flag_v takes captured alu_ovf only if op==3'b000; otherwise it is forced to 0.
  - ovf_sticky is set when flag_v is written as 1.
- Timing: instr_ready and ld_ready=0 in EXEC and WB, so ld_valid is ignored in those states. Return to IDLE after WB. Accept at edge N gives done in cycle N+2. Max throughput is one instruction per 3 cycles.
- Register aliasing: rd may equal rs1 or rs2. Operands are read in EXEC, before writeback, so the old values are used.
- Sticky overflow:
  - clr_sticky=1 clears ovf_sticky in any state.
  - If clear and set occur in the same cycle, set wins.
- Outputs alu_a/alu_b/alu_op hold their last values outside EXEC.
- Reset asserted in any state aborts the instruction: no writeback, no done, and all state returns to reset values on that edge.
- All arithmetic is in the ALU. This block performs no width extension and no result modification.

Test Plan:
- Load r1=0x7FFF, r2=0x0001, then ADD rd=3 (instr 0x0CA). Required: done 2 cycles after accept, r3=result=0x8000, flag_s=1, flag_v=1, flag_z=0, flag_p=0, ovf_sticky=1.
- Load r4=r5=0x0005, then SUB rd=6 rs1=4 rs2=5. Required: result=0x0000, flag_z=1, flag_p=1, flag_s=0, flag_v=0; ovf_sticky stays 1 from the prior test.
- XOR with r1=0x00FF, r2=0x0F0F, and the ALU model driving alu_sign=1, alu_ovf=1. Required: result=0x0FF0, flag_s=0, flag_v=0, flag_p=1, flag_z=0.
- clr_sticky pulsed in the WB cycle of an overflowing ADD. Required: ovf_sticky=1 (set wins). A later clr_sticky alone gives ovf_sticky=0.
- Aliasing: r1=0x0003, ADD rd=1 rs1=1 rs2=1. Required: r1=0x0006. Check instr_ready=0 and ld_valid ignored during EXEC/WB; the next instruction is accepted only in IDLE.
- Assert rst during EXEC of an ADD with rd=2. Required: done never pulses, r2=0, all flags 0, instr_ready=1 the cycle after reset deasserts.
